// File: rtl/gray_xfer_counter.sv
// gray_xfer_counter: up/down event counter for fast-to-slow clock-domain crossings.
// The binary count and a registered Gray copy update on the same edge. The Gray
// copy changes one bit per step, so a slower domain can take gray_count through a
// 2-FF synchroniser without multi-bit skew. Only gray_count should cross domains.
module gray_xfer_counter #(
  parameter int WIDTH    = 4,   // count width in bits, >= 2
  parameter bit SATURATE = 1'b0, // 0: wrap modulo 2^WIDTH, 1: hold at the limits
  parameter bit DOWN_EN  = 1'b1  // 1: up_dn honoured, 0: always count up
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             clr,
  output logic [WIDTH-1:0] bin_count,
  output logic [WIDTH-1:0] gray_count,
  output logic             wrap,
  output logic             sat_hit
);

  localparam logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             wrap_q, wrap_d;
  logic             sat_q, sat_d;
  logic             dir_up;
  logic             at_limit;

  // Next-state: clr beats en, en beats hold; gray derives from the next binary value.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    bin_d    = bin_q;
    wrap_d   = 1'b0;
    sat_d    = 1'b0;
    dir_up   = DOWN_EN ? up_dn : 1'b1;
    at_limit = dir_up ? (bin_q == MAX_VAL) : (bin_q == '0);

    if (clr) begin
      bin_d = '0;
    end else if (en) begin
      if (SATURATE && at_limit) begin
        sat_d = 1'b1;
      end else begin
        bin_d  = dir_up ? (bin_q + ONE) : (bin_q - ONE);
        // In wrap mode, stepping off a limit is exactly the wrap event.
        wrap_d = at_limit;
      end
    end

    gray_d = bin_d ^ (bin_d >> 1);
  end

  // State register: async clear, otherwise load all next-state values together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bin_q  <= '0;
      gray_q <= '0;
      wrap_q <= 1'b0;
      sat_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values of the others.
      bin_q  <= bin_d;
      gray_q <= gray_d;
      wrap_q <= wrap_d;
      sat_q  <= sat_d;
    end
  end

  assign bin_count  = bin_q;
  assign gray_count = gray_q;
  assign wrap       = wrap_q;
  assign sat_hit    = sat_q;

endmodule

// File: tb/tb_gray_xfer_counter.sv
// Directed bench for gray_xfer_counter. Three instances share one set of inputs:
// wrap mode with down enabled, wrap mode up-only, and saturate mode with down enabled.
module tb_gray_xfer_counter;

  logic clk = 1'b0;
  logic clk2 = 1'b0;
  logic reset_n = 1'b1;
  logic en = 1'b0;
  logic up_dn = 1'b1;
  logic clr = 1'b0;

  logic [3:0] w_bin, w_gray, u_bin, u_gray, s_bin, s_gray;
  logic       w_wrap, w_sat, u_wrap, u_sat, s_wrap, s_sat;

  int n_vec = 0;
  int n_err = 0;

  logic [3:0] gray_tab [16] = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
                                4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};

  always #5  clk  = ~clk;
  always #10 clk2 = ~clk2;

  gray_xfer_counter #(.WIDTH(4), .SATURATE(1'b0), .DOWN_EN(1'b1)) u_wrapdn (
    .clk(clk), .reset_n(reset_n), .en(en), .up_dn(up_dn), .clr(clr),
    .bin_count(w_bin), .gray_count(w_gray), .wrap(w_wrap), .sat_hit(w_sat));

  gray_xfer_counter #(.WIDTH(4), .SATURATE(1'b0), .DOWN_EN(1'b0)) u_uponly (
    .clk(clk), .reset_n(reset_n), .en(en), .up_dn(up_dn), .clr(clr),
    .bin_count(u_bin), .gray_count(u_gray), .wrap(u_wrap), .sat_hit(u_sat));

  gray_xfer_counter #(.WIDTH(4), .SATURATE(1'b1), .DOWN_EN(1'b1)) u_satdn (
    .clk(clk), .reset_n(reset_n), .en(en), .up_dn(up_dn), .clr(clr),
    .bin_count(s_bin), .gray_count(s_gray), .wrap(s_wrap), .sat_hit(s_sat));

  // Receiver side: 2-FF synchroniser on the slower clock.
  logic [3:0] sync1, sync2;
  always_ff @(posedge clk2 or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= w_gray;
      sync2 <= sync1;
    end
  end

  function automatic logic [3:0] gray2bin(input logic [3:0] g);
    logic [3:0] b;
    b[3] = g[3];
    for (int i = 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clr();
    en = 1'b0; clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    #1 reset_n = 1'b0;
    #1;
    n_vec++;
    if ({w_bin, w_gray, w_wrap, w_sat} !== 10'd0) begin
      n_err++; $display("FAIL reset_async_w: got %h want 0", {w_bin, w_gray, w_wrap, w_sat});
    end
    n_vec++;
    if ({s_bin, s_gray, s_wrap, s_sat, u_bin, u_gray} !== 18'd0) begin
      n_err++; $display("FAIL reset_async_su: got %h want 0", {s_bin, s_gray, s_wrap, s_sat, u_bin, u_gray});
    end
    tick(); tick();
    reset_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_vec++;
      if ({w_bin, w_gray, w_wrap, w_sat, s_sat, u_wrap} !== 12'd0) begin
        n_err++; $display("FAIL reset_idle[%0d]: got %h want 0", k, {w_bin, w_gray, w_wrap, w_sat, s_sat, u_wrap});
      end
    end
  endtask

  task automatic test_wrap_up();
    logic [3:0] prev_g;
    logic [3:0] exp_b;
    logic [3:0] exp_s;
    prev_g = w_gray;
    en = 1'b1; up_dn = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      tick();
      exp_b = 4'(k % 16);
      exp_s = (k >= 15) ? 4'd15 : 4'(k);
      n_vec++;
      if (w_bin !== exp_b || w_gray !== gray_tab[exp_b]) begin
        n_err++; $display("FAIL up_count[%0d]: got bin %0d gray %0d want bin %0d gray %0d", k, w_bin, w_gray, exp_b, gray_tab[exp_b]);
      end
      n_vec++;
      if (w_wrap !== (k == 16) || w_sat !== 1'b0) begin
        n_err++; $display("FAIL up_wrap[%0d]: got wrap %b sat %b want wrap %b sat 0", k, w_wrap, w_sat, (k == 16));
      end
      n_vec++;
      if ($countones(w_gray ^ prev_g) !== 1) begin
        n_err++; $display("FAIL up_onebit[%0d]: got %0d bits changed want 1", k, $countones(w_gray ^ prev_g));
      end
      n_vec++;
      if (u_bin !== exp_b || s_bin !== exp_s || s_sat !== (k >= 16) || s_wrap !== 1'b0) begin
        n_err++; $display("FAIL up_other[%0d]: got u %0d s %0d sat %b want u %0d s %0d sat %b", k, u_bin, s_bin, s_sat, exp_b, exp_s, (k >= 16));
      end
      prev_g = w_gray;
    end
    en = 1'b0;
  endtask

  task automatic test_down();
    logic [3:0] exp_w [2] = '{4'd15, 4'd14};
    logic [3:0] exp_g [2] = '{4'd8, 4'd9};
    logic [3:0] exp_u [2] = '{4'd1, 4'd2};
    do_clr();
    n_vec++;
    if ({w_bin, w_gray, u_bin, s_bin, s_sat} !== 17'd0) begin
      n_err++; $display("FAIL clr_all: got %h want 0", {w_bin, w_gray, u_bin, s_bin, s_sat});
    end
    en = 1'b1; up_dn = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      n_vec++;
      if (w_bin !== exp_w[k] || w_gray !== exp_g[k] || w_wrap !== (k == 0)) begin
        n_err++; $display("FAIL down_w[%0d]: got bin %0d gray %0d wrap %b want %0d %0d %b", k, w_bin, w_gray, w_wrap, exp_w[k], exp_g[k], (k == 0));
      end
      n_vec++;
      if (u_bin !== exp_u[k] || u_wrap !== 1'b0) begin
        n_err++; $display("FAIL down_uponly[%0d]: got bin %0d wrap %b want %0d 0", k, u_bin, u_wrap, exp_u[k]);
      end
      n_vec++;
      if (s_bin !== 4'd0 || s_sat !== 1'b1 || s_wrap !== 1'b0) begin
        n_err++; $display("FAIL down_sat[%0d]: got bin %0d sat %b wrap %b want 0 1 0", k, s_bin, s_sat, s_wrap);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_saturate();
    logic [3:0] exp_b;
    do_clr();
    en = 1'b1; up_dn = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      exp_b = (k >= 15) ? 4'd15 : 4'(k);
      n_vec++;
      if (s_bin !== exp_b || s_gray !== gray_tab[exp_b] || s_sat !== (k >= 16) || s_wrap !== 1'b0) begin
        n_err++; $display("FAIL sat_up[%0d]: got bin %0d gray %0d sat %b wrap %b want %0d %0d %b 0", k, s_bin, s_gray, s_sat, s_wrap, exp_b, gray_tab[exp_b], (k >= 16));
      end
    end
    up_dn = 1'b0;
    for (int k = 1; k <= 18; k++) begin
      tick();
      exp_b = (k >= 15) ? 4'd0 : 4'(15 - k);
      n_vec++;
      if (s_bin !== exp_b || s_gray !== gray_tab[exp_b] || s_sat !== (k >= 16) || s_wrap !== 1'b0) begin
        n_err++; $display("FAIL sat_down[%0d]: got bin %0d gray %0d sat %b wrap %b want %0d %0d %b 0", k, s_bin, s_gray, s_sat, s_wrap, exp_b, gray_tab[exp_b], (k >= 16));
      end
    end
    en = 1'b0; up_dn = 1'b1;
  endtask

  task automatic test_clr_priority();
    logic [3:0] exp_b;
    do_clr();
    en = 1'b1; up_dn = 1'b1;
    repeat (9) tick();
    n_vec++;
    if (w_bin !== 4'd9) begin
      n_err++; $display("FAIL clr_setup: got bin %0d want 9", w_bin);
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    n_vec++;
    if ({w_bin, w_gray, w_wrap, w_sat, u_bin, s_bin, s_sat} !== 17'd0) begin
      n_err++; $display("FAIL clr_over_en: got %h want 0", {w_bin, w_gray, w_wrap, w_sat, u_bin, s_bin, s_sat});
    end
    exp_b = 4'd0;
    for (int k = 0; k < 6; k++) begin
      en = (k % 2 == 0);
      if (en) exp_b = exp_b + 4'd1;
      tick();
      n_vec++;
      if (w_bin !== exp_b || w_gray !== gray_tab[exp_b] || w_wrap !== 1'b0) begin
        n_err++; $display("FAIL en_toggle[%0d]: got bin %0d gray %0d wrap %b want %0d %0d 0", k, w_bin, w_gray, w_wrap, exp_b, gray_tab[exp_b]);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_async_reset_sync();
    logic [3:0] dec;
    logic [3:0] prev_dec;
    do_clr();
    en = 1'b1; up_dn = 1'b1;
    repeat (7) tick();
    n_vec++;
    if (w_bin !== 4'd7 || w_gray !== 4'd4) begin
      n_err++; $display("FAIL areset_setup: got bin %0d gray %0d want 7 4", w_bin, w_gray);
    end
    #2 reset_n = 1'b0;
    #1;
    n_vec++;
    if ({w_bin, w_gray, w_wrap, w_sat, u_bin, s_bin} !== 18'd0) begin
      n_err++; $display("FAIL areset_midcycle: got %h want 0", {w_bin, w_gray, w_wrap, w_sat, u_bin, s_bin});
    end
    tick();
    n_vec++;
    if (w_bin !== 4'd0) begin
      n_err++; $display("FAIL areset_held: got bin %0d want 0", w_bin);
    end
    en = 1'b0;
    reset_n = 1'b1;
    tick();
    n_vec++;
    if (w_bin !== 4'd0) begin
      n_err++; $display("FAIL areset_en_lost: got bin %0d want 0", w_bin);
    end
    prev_dec = 4'd0;
    en = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (k == 14) en = 1'b0;
      tick();
      dec = gray2bin(sync2);
      n_vec++;
      if (dec < prev_dec || dec > w_bin) begin
        n_err++; $display("FAIL sync_monotonic[%0d]: got %0d want >= %0d and <= %0d", k, dec, prev_dec, w_bin);
      end
      prev_dec = dec;
    end
    n_vec++;
    if (gray2bin(sync2) !== 4'd14) begin
      n_err++; $display("FAIL sync_final: got %0d want 14", gray2bin(sync2));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_wrap_up();
    test_down();
    test_saturate();
    test_clr_priority();
    test_async_reset_sync();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
